bp_axi_rd_arbiter: RTL and testbench

- Two-requester AXI4 read-channel (AR/R) arbiter. Shares one downstream AXI4 read slave between two upstream read masters.
- Typical placements: an NBF loader and a debug reader sharing the host read port, or a host and bootrom client sharing one memory.
- Round-robin grant per burst. Exactly one burst is outstanding downstream at a time.
- Write channels are outside this block.

---
 rtl/bp_axi_rd_arbiter.sv | 177 +++++++++++++++++
 tb/tb_bp_axi_rd_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// bp_axi_rd_arbiter
//   Two-requester AXI4 read-channel (AR/R) arbiter. Shares one downstream
//   read slave between two upstream read masters, granting one whole burst at
//   a time in round-robin order. Only one burst is outstanding downstream.
//
// Ports
//   aclk, reset            clock, synchronous active-high reset
//   s_axi_ar*              upstream AR fields, requester i at slice i
//   s_axi_arvalid/arready  per-requester AR handshake
//   s_axi_r*               R fields broadcast to both slices
//   s_axi_rvalid/rready    per-requester R handshake (only grantee sees rvalid)
//   m_axi_ar*/r*           downstream AR/R channel
//   grant_count_o          per-requester AR handshake counters, requester i at
//                          bits [32*i +: 32]; only with BP_AXI_RD_ARB_STATS_EN
//
// Optional feature macro: BP_AXI_RD_ARB_STATS_EN
// ---------------------------------------------------------------------------
module bp_axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int num_req_p  = 2
) (
    input  logic                    aclk,
    input  logic                    reset,

    input  logic [2*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2*ID_WIDTH-1:0]   s_axi_arid,
    input  logic [15:0]             s_axi_arlen,
    input  logic [5:0]              s_axi_arsize,
    input  logic [3:0]              s_axi_arburst,
    input  logic [1:0]              s_axi_arvalid,
    output logic [1:0]              s_axi_arready,

    output logic [2*DATA_WIDTH-1:0] s_axi_rdata,
    output logic [2*ID_WIDTH-1:0]   s_axi_rid,
    output logic [3:0]              s_axi_rresp,
    output logic [1:0]              s_axi_rlast,
    output logic [1:0]              s_axi_rvalid,
    input  logic [1:0]              s_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
`ifdef BP_AXI_RD_ARB_STATS_EN
    output logic [63:0]             grant_count_o,
`endif
    output logic                    m_axi_rready
);

    if (num_req_p != 2) begin : g_bad_num_req
        $error("bp_axi_rd_arbiter: num_req_p must be 2");
    end

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_addr = 2'd1,
        e_data = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   prio_q,  prio_d;

    logic   in_addr, in_data;
    logic   winner;
    logic   ar_hs, r_last_hs;

    assign in_addr = (state_q == e_addr);
    assign in_data = (state_q == e_data);

    // A lone requester wins outright; a tie goes to the preferred one.
    assign winner = (&s_axi_arvalid) ? prio_q : s_axi_arvalid[1];

    // AR fields are not registered: the grantee holds them stable until arready.
    assign m_axi_araddr  = grant_q ? s_axi_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_araddr[ADDR_WIDTH-1:0];
    assign m_axi_arid    = grant_q ? s_axi_arid[2*ID_WIDTH-1:ID_WIDTH]       : s_axi_arid[ID_WIDTH-1:0];
    assign m_axi_arlen   = grant_q ? s_axi_arlen[15:8]                       : s_axi_arlen[7:0];
    assign m_axi_arsize  = grant_q ? s_axi_arsize[5:3]                       : s_axi_arsize[2:0];
    assign m_axi_arburst = grant_q ? s_axi_arburst[3:2]                      : s_axi_arburst[1:0];

    // R payload goes to both slices; only rvalid is steered.
    assign s_axi_rdata = {2{m_axi_rdata}};
    assign s_axi_rid   = {2{m_axi_rid}};
    assign s_axi_rresp = {2{m_axi_rresp}};
    assign s_axi_rlast = {2{m_axi_rlast}};

    always_comb begin
        s_axi_arready          = 2'b00;
        s_axi_rvalid           = 2'b00;
        m_axi_arvalid          = in_addr & s_axi_arvalid[grant_q];
        s_axi_arready[grant_q] = in_addr & m_axi_arready;
        s_axi_rvalid[grant_q]  = in_data & m_axi_rvalid;
        m_axi_rready           = in_data & s_axi_rready[grant_q];
    end

    assign ar_hs     = m_axi_arvalid & m_axi_arready;
    assign r_last_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        unique case (state_q)
            e_idle: begin
                if (|s_axi_arvalid) begin
                    grant_d = winner;
                    state_d = e_addr;
                end
            end
            e_addr: begin
                if (ar_hs) state_d = e_data;
            end
            e_data: begin
                // Hand preference to the other requester once this burst ends.
                if (r_last_hs) begin
                    state_d = e_idle;
                    prio_d  = ~grant_q;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= e_idle;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

`ifdef BP_AXI_RD_ARB_STATS_EN
    logic [63:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (ar_hs) begin
            if (grant_q) grant_cnt_d[63:32] = grant_cnt_q[63:32] + 32'd1;
            else         grant_cnt_d[31:0]  = grant_cnt_q[31:0]  + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) grant_cnt_q <= '0;
        else       grant_cnt_q <= grant_cnt_d;
    end

    assign grant_count_o = grant_cnt_q;
`endif

`ifndef SYNTHESIS
    // The grantee must hold arvalid until the address is accepted.
    ar_hold_a: assert property (@(posedge aclk) disable iff (reset)
        (in_addr && s_axi_arvalid[grant_q] && !m_axi_arready) |=> s_axi_arvalid[grant_q]);

    // Downstream must not return data unless a burst is in its data phase.
    r_spurious_a: assert property (@(posedge aclk) disable iff (reset)
        m_axi_rvalid |-> in_data);
`endif

endmodule

// File: tb/tb_bp_axi_rd_arbiter.sv
module tb_bp_axi_rd_arbiter;

    localparam logic [63:0] K = 64'h9E37_79B9_7F4A_7C15;

    logic         aclk = 1'b0;
    logic         reset;
    logic [127:0] s_axi_araddr;
    logic [7:0]   s_axi_arid;
    logic [15:0]  s_axi_arlen;
    logic [5:0]   s_axi_arsize;
    logic [3:0]   s_axi_arburst;
    logic [1:0]   s_axi_arvalid;
    logic [1:0]   s_axi_arready;
    logic [127:0] s_axi_rdata;
    logic [7:0]   s_axi_rid;
    logic [3:0]   s_axi_rresp;
    logic [1:0]   s_axi_rlast;
    logic [1:0]   s_axi_rvalid;
    logic [1:0]   s_axi_rready;
    logic [63:0]  m_axi_araddr;
    logic [3:0]   m_axi_arid;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [63:0]  m_axi_rdata;
    logic [3:0]   m_axi_rid;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
`ifdef BP_AXI_RD_ARB_STATS_EN
    logic [63:0]  grant_count_o;
`endif

    always #5 aclk = ~aclk;

    bp_axi_rd_arbiter dut (
        .aclk(aclk), .reset(reset),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
`ifdef BP_AXI_RD_ARB_STATS_EN
        .grant_count_o(grant_count_o),
`endif
        .m_axi_rready(m_axi_rready)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One row per cycle: {arvalid, m_arready, m_rvalid, m_rlast, s_rready |
    //                     exp m_arvalid, exp s_arready, exp s_rvalid, exp m_rready}
    typedef struct packed {
        logic [1:0] av;  logic arr; logic rv; logic rl; logic [1:0] rr;
        logic mav; logic [1:0] sar; logic [1:0] srv; logic mrr;
    } vec_t;

    vec_t tbl [18];

    task automatic idle_inputs();
        s_axi_arvalid = 2'b00; s_axi_rready = 2'b00;
        m_axi_arready = 1'b0;  m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge aclk);
        #1 reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [3:0] id, input logic [7:0] len);
        s_axi_araddr[i*64 +: 64] = a;
        s_axi_arid[i*4 +: 4]     = id;
        s_axi_arlen[i*8 +: 8]    = len;
    endtask

    // Both requesters hold arvalid with single-beat bursts; grants must alternate
    // starting from requester 0, spaced addr/data/idle = 3 cycles apart.
    task automatic run_alt(input int n);
        int  done = 0, ng = 0, last_c = 0;
        bit  rv_nxt = 1'b0;
        set_req(0, 64'hA000, 4'h1, 8'd0);
        set_req(1, 64'hB000, 4'h9, 8'd0);
        s_axi_arvalid = 2'b11; m_axi_arready = 1'b1; s_axi_rready = 2'b11; m_axi_rlast = 1'b1;
        for (int c = 0; c < 40 * n && done < n; c++) begin
            m_axi_rvalid = rv_nxt;
            #1;
            rv_nxt = 1'b0;
            if (s_axi_arready != 2'b00) begin
                chk("alt_grant", {127'd0, s_axi_arready[1]}, ng % 2);
                if (ng > 0) chk("alt_gap", c - last_c, 3);
                last_c = c; ng++; rv_nxt = 1'b1;
            end
            if (m_axi_rvalid && m_axi_rready) done++;
            @(posedge aclk); #1;
        end
        s_axi_arvalid = 2'b00; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        chk("alt_done", done, n);
    endtask

    // Random-phase agents and reference model
    logic [63:0] rq_addr [2];
    logic [3:0]  rq_id   [2];
    logic [7:0]  rq_len  [2];
    bit          rq_pend [2];
    bit          rq_wait [2];
    int          rq_beat [2];
    logic [63:0] sl_addr;
    logic [3:0]  sl_id;
    int          sl_len, sl_beat;
    bit          sl_act;
    int          own, pref, beats_left;
    bit          aph;
    int          mcnt [2];

    task automatic run_random(input int ncyc);
        logic       e_mav, e_mrr;
        logic [1:0] e_sar, e_srv, p_av, p_rr, h_ar, h_rb;
        logic       p_arr, p_rv, h_mar, h_r;
        for (int i = 0; i < 2; i++) begin
            rq_pend[i] = 0; rq_wait[i] = 0; rq_beat[i] = 0; mcnt[i] = 0;
        end
        sl_act = 0; sl_beat = 0; sl_len = 0; sl_addr = '0; sl_id = '0;
        own = -1; pref = 0; aph = 0; beats_left = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 2; i++) begin
                s_axi_arvalid[i] = rq_pend[i];
                set_req(i, rq_addr[i], rq_id[i], rq_len[i]);
                s_axi_rready[i] = ($urandom_range(9) < 7);
            end
            m_axi_arready = ($urandom_range(9) < 6);
            m_axi_rvalid  = sl_act && ($urandom_range(9) < 7);
            m_axi_rdata   = sl_addr ^ (64'(sl_beat) * K);
            m_axi_rid     = sl_id;
            m_axi_rresp   = 2'(sl_beat);
            m_axi_rlast   = (sl_beat == sl_len);
            #1;
            e_mav = (own >= 0 && aph) ? s_axi_arvalid[own] : 1'b0;
            e_mrr = (own >= 0 && !aph) ? s_axi_rready[own] : 1'b0;
            e_sar = 2'b00; e_srv = 2'b00;
            if (own >= 0 && aph && m_axi_arready) e_sar[own] = 1'b1;
            if (own >= 0 && !aph && m_axi_rvalid) e_srv[own] = 1'b1;
            chk("rnd_m_arvalid", m_axi_arvalid, e_mav);
            chk("rnd_s_arready", s_axi_arready, e_sar);
            chk("rnd_s_rvalid", s_axi_rvalid, e_srv);
            chk("rnd_m_rready", m_axi_rready, e_mrr);
            chk("rnd_r_bcast", {s_axi_rdata[127:64], s_axi_rid, s_axi_rresp, s_axi_rlast},
                {m_axi_rdata, {2{m_axi_rid}}, {2{m_axi_rresp}}, {2{m_axi_rlast}}});
            if (e_mav)
                chk("rnd_ar_fields", {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
                    {rq_addr[own], rq_id[own], rq_len[own], s_axi_arsize[own*3 +: 3], s_axi_arburst[own*2 +: 2]});
            for (int i = 0; i < 2; i++) begin
                h_ar[i] = s_axi_arvalid[i] & s_axi_arready[i];
                h_rb[i] = s_axi_rvalid[i] & s_axi_rready[i];
                if (h_rb[i]) begin
                    chk("rnd_r_to_waiter", rq_wait[i], 1);
                    if (rq_wait[i])
                        chk("rnd_r_beat", {s_axi_rdata[i*64 +: 64], s_axi_rid[i*4 +: 4], s_axi_rlast[i]},
                            {rq_addr[i] ^ (64'(rq_beat[i]) * K), rq_id[i], rq_beat[i] == int'(rq_len[i])});
                end
            end
            h_mar = m_axi_arvalid & m_axi_arready;
            h_r   = m_axi_rvalid & m_axi_rready;
            p_av = s_axi_arvalid; p_arr = m_axi_arready; p_rv = m_axi_rvalid; p_rr = s_axi_rready;
            @(posedge aclk); #1;
            // reference model: one burst owner at a time, round-robin on ties
            if (own < 0) begin
                if (p_av != 2'b00) begin
                    own = (p_av == 2'b11) ? pref : (p_av[1] ? 1 : 0);
                    aph = 1;
                end
            end else if (aph) begin
                if (p_av[own] && p_arr) begin
                    aph = 0; beats_left = int'(rq_len[own]) + 1; mcnt[own]++;
                end
            end else if (p_rv && p_rr[own]) begin
                beats_left--;
                if (beats_left == 0) begin pref = 1 - own; own = -1; end
            end
            // downstream slave agent
            if (h_mar) begin
                sl_act = 1; sl_addr = m_axi_araddr; sl_id = m_axi_arid; sl_len = int'(m_axi_arlen); sl_beat = 0;
            end else if (h_r) begin
                if (sl_beat == sl_len) sl_act = 0;
                sl_beat++;
            end
            // requester agents
            for (int i = 0; i < 2; i++) begin
                if (h_ar[i]) begin rq_pend[i] = 0; rq_wait[i] = 1; rq_beat[i] = 0; end
                if (h_rb[i] && rq_wait[i]) begin
                    if (rq_beat[i] == int'(rq_len[i])) rq_wait[i] = 0;
                    rq_beat[i]++;
                end
                if (!rq_pend[i] && !rq_wait[i] && $urandom_range(3) == 0) begin
                    rq_pend[i] = 1;
                    rq_addr[i] = {$urandom, $urandom};
                    rq_id[i]   = {i[0], 3'($urandom_range(7))};
                    rq_len[i]  = 8'($urandom_range(3));
                end
            end
        end
        idle_inputs();
`ifdef BP_AXI_RD_ARB_STATS_EN
        chk("rnd_grant_count", grant_count_o, {32'(mcnt[1]), 32'(mcnt[0])});
`endif
    endtask

    initial begin
        tbl = '{
            13'b01_1_0_0_00_0_00_00_0, 13'b01_0_0_0_00_1_00_00_0, 13'b01_1_0_0_00_1_01_00_0,
            13'b00_0_1_0_01_0_00_01_1, 13'b10_0_1_1_00_0_00_01_0, 13'b10_0_1_1_01_0_00_01_1,
            13'b10_0_0_0_00_0_00_00_0, 13'b10_1_0_0_00_1_10_00_0, 13'b11_1_1_1_10_0_00_10_1,
            13'b11_0_0_0_00_0_00_00_0, 13'b11_1_0_0_00_1_01_00_0, 13'b10_0_1_1_11_0_00_01_1,
            13'b10_0_0_0_00_0_00_00_0, 13'b11_1_0_0_00_1_10_00_0, 13'b11_0_1_0_10_0_00_10_1,
            13'b11_0_1_1_10_0_00_10_1, 13'b11_0_0_0_00_0_00_00_0, 13'b11_0_0_0_00_1_00_00_0
        };
        s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
        s_axi_arsize = 6'b010_011; s_axi_arburst = 4'b10_01;
        idle_inputs();

        // reset state: nothing asserted even with every input active
        reset = 1'b1;
        s_axi_arvalid = 2'b11; m_axi_arready = 1'b1; s_axi_rready = 2'b11; m_axi_rvalid = 1'b1;
        @(posedge aclk); #1;
        chk("rst_m_arvalid", m_axi_arvalid, 0);
        chk("rst_s_arready", s_axi_arready, 0);
        chk("rst_s_rvalid", s_axi_rvalid, 0);
        chk("rst_m_rready", m_axi_rready, 0);
        do_reset();

        // per-cycle handshake table
        for (int r = 0; r < 18; r++) begin
            s_axi_arvalid = tbl[r].av; m_axi_arready = tbl[r].arr;
            m_axi_rvalid = tbl[r].rv; m_axi_rlast = tbl[r].rl; s_axi_rready = tbl[r].rr;
            #1;
            chk($sformatf("tbl%0d_m_arvalid", r), m_axi_arvalid, tbl[r].mav);
            chk($sformatf("tbl%0d_s_arready", r), s_axi_arready, tbl[r].sar);
            chk($sformatf("tbl%0d_s_rvalid", r), s_axi_rvalid, tbl[r].srv);
            chk($sformatf("tbl%0d_m_rready", r), m_axi_rready, tbl[r].mrr);
            @(posedge aclk); #1;
        end
        do_reset();

        // single request, 4-beat burst to requester 0
        set_req(0, 64'h1000, 4'h5, 8'd3);
        s_axi_arvalid = 2'b01; m_axi_arready = 1'b1; s_axi_rready = 2'b11;
        #1 chk("sr_latency", m_axi_arvalid, 0);
        @(posedge aclk); #1;
        chk("sr_arvalid", m_axi_arvalid, 1);
        chk("sr_fields", {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
            {64'h1000, 4'h5, 8'd3, 3'd3, 2'd1});
        chk("sr_arready", s_axi_arready, 2'b01);
        @(posedge aclk); #1;
        s_axi_arvalid = 2'b00;
        for (int b = 0; b < 4; b++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = 64'hD0 + 64'(b); m_axi_rid = 4'h5; m_axi_rlast = (b == 3);
            #1;
            chk("sr_rvalid", s_axi_rvalid, 2'b01);
            chk("sr_rbeat", {s_axi_rdata[63:0], s_axi_rid[3:0], s_axi_rlast[0]},
                {64'hD0 + 64'(b), 4'h5, b == 3});
            @(posedge aclk); #1;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        s_axi_arvalid = 2'b10; set_req(1, 64'h1100, 4'h8, 8'd0);
        #1 chk("sr_bubble", m_axi_arvalid, 0);
        @(posedge aclk); #1;
        chk("sr_next_grant", s_axi_arready, 2'b10);
        do_reset();

        run_alt(5);
`ifdef BP_AXI_RD_ARB_STATS_EN
        chk("stat_3_2", grant_count_o, {32'd2, 32'd3});
`endif
        do_reset();
        run_alt(8);
        do_reset();

        // reset on the third beat of a 4-beat burst
        set_req(0, 64'h2000, 4'h3, 8'd3);
        s_axi_arvalid = 2'b01; m_axi_arready = 1'b1; s_axi_rready = 2'b11;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        s_axi_arvalid = 2'b00; m_axi_rvalid = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        reset = 1'b1; s_axi_arvalid = 2'b11;
        @(posedge aclk); #1;
        chk("rmb_m_arvalid", m_axi_arvalid, 0);
        chk("rmb_s_arready", s_axi_arready, 0);
        chk("rmb_s_rvalid", s_axi_rvalid, 0);
        chk("rmb_m_rready", m_axi_rready, 0);
`ifdef BP_AXI_RD_ARB_STATS_EN
        chk("rmb_count_clr", grant_count_o, 0);
`endif
        reset = 1'b0; m_axi_rvalid = 1'b0; s_axi_arvalid = 2'b10;
        set_req(1, 64'h3000, 4'hA, 8'd0);
        @(posedge aclk); #1;
        chk("rmb_new_grant", {m_axi_arvalid, s_axi_arready, m_axi_araddr}, {1'b1, 2'b10, 64'h3000});
        @(posedge aclk); #1;
        s_axi_arvalid = 2'b00; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 4'hA;
        #1 chk("rmb_new_beat", {s_axi_rvalid, m_axi_rready, s_axi_rid[7:4]}, {2'b10, 1'b1, 4'hA});
        @(posedge aclk); #1;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

`ifdef BP_AXI_RD_ARB_STATS_EN
        do_reset();
        force dut.grant_cnt_q = 64'h0000_0000_FFFF_FFFF;
        @(posedge aclk); #1;
        release dut.grant_cnt_q;
        run_alt(1);
        chk("stat_wrap", grant_count_o, 64'h0);
`endif

        do_reset();
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
